// File: rtl/instruction_loader.sv
// Boot-time writer for the instruction memory: turns a framed byte stream
// (32-bit word count + little-endian words) into one-cycle memory write strobes.
module instruction_loader #(
    parameter int unsigned MEMORY_SIZE  = 1024,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned WORD_CAPACITY = MEMORY_SIZE / 4;
    localparam int unsigned WORD_CNT_W    = $clog2(WORD_CAPACITY) + 1;
    localparam logic [31:0] WORD_LIMIT    = 32'(WORD_CAPACITY);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [1:0]              r_byte_cnt;
    logic [WORD_CNT_W-1:0]   r_word_cnt;
    logic [31:0]             r_word_total;
    logic [31:0]             r_assembly;
    logic [31:0]             w_assembled;
    logic [31:0]             w_word_cnt_inc;
    logic                    w_transfer;
    logic                    w_last_byte;
    logic                    w_start_load;

    logic                    r_byte_ready;
    logic                    r_mem_write_enable;
    logic [31:0]             r_mem_write_address;
    logic [31:0]             r_mem_write_data;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;

    assign w_word_cnt_inc = 32'(r_word_cnt) + 32'd1;

    // Next-state logic. The incoming byte is merged into its lane so that the
    // completed word (or header) is available in the same cycle as the 4th byte.
    always_comb begin
        w_assembled = r_assembly;
        w_assembled[{r_byte_cnt, 3'b000} +: 8] = byte_in;
        w_transfer   = byte_valid && r_byte_ready;
        w_last_byte  = w_transfer && (r_byte_cnt == 2'd3);
        w_start_load = 1'b0;
        w_state_next = r_state;

        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_start_load = 1'b1;
                    w_state_next = S_HEADER;
                end
            end
            S_HEADER: begin
                if (w_last_byte) begin
                    if (w_assembled > WORD_LIMIT) begin
                        w_state_next = S_ERROR;
                    end else if (w_assembled == 32'd0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_last_byte) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_word_cnt_inc == r_word_total) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_DATA;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: status outputs are decoded from the *next* state and registered, so
    // they change on the same edge as the state itself with no combinational path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state             <= S_IDLE;
            r_byte_cnt          <= 2'd0;
            r_word_cnt          <= '0;
            r_word_total        <= 32'd0;
            r_assembly          <= 32'd0;
            r_byte_ready        <= 1'b0;
            r_mem_write_enable  <= 1'b0;
            r_mem_write_address <= 32'd0;
            r_mem_write_data    <= 32'd0;
            r_busy              <= 1'b0;
            r_done              <= 1'b0;
            r_error             <= 1'b0;
        end else begin
            r_state            <= w_state_next;
            r_byte_ready       <= (w_state_next == S_HEADER) || (w_state_next == S_DATA);
            r_busy             <= (w_state_next == S_HEADER) || (w_state_next == S_DATA) ||
                                  (w_state_next == S_WRITE);
            r_mem_write_enable <= (w_state_next == S_WRITE);
            r_done             <= (w_state_next == S_DONE);
            r_error            <= (w_state_next == S_ERROR);

            if (w_start_load) begin
                r_byte_cnt   <= 2'd0;
                r_word_cnt   <= '0;
                r_word_total <= 32'd0;
                r_assembly   <= 32'd0;
            end else begin
                if (w_transfer) begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    r_assembly <= w_assembled;
                end
                if ((r_state == S_HEADER) && w_last_byte) begin
                    r_word_total <= w_assembled;
                end
                // Address and data only move when a word completes; they hold otherwise.
                if ((r_state == S_DATA) && w_last_byte) begin
                    r_mem_write_address <= BASE_ADDRESS + (32'(r_word_cnt) << 2);
                    r_mem_write_data    <= w_assembled;
                end
                if (r_state == S_WRITE) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
            end
        end
    end

    assign byte_ready        = r_byte_ready;
    assign mem_write_enable  = r_mem_write_enable;
    assign mem_write_address = r_mem_write_address;
    assign mem_write_data    = r_mem_write_data;
    assign busy              = r_busy;
    assign done              = r_done;
    assign error             = r_error;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a default-parameter instance and a
// BASE_ADDRESS=0x100 instance share one stimulus stream.
module tb_instruction_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_write_enable;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        busy;
    logic        done;
    logic        error;

    logic        b_byte_ready;
    logic        b_mem_write_enable;
    logic [31:0] b_mem_write_address;
    logic [31:0] b_mem_write_data;
    logic        b_busy;
    logic        b_done;
    logic        b_error;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    logic [31:0] qb_addr [$];
    int          ready_during_write = 0;

    logic [7:0] basic_bytes [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                                     8'h13, 8'h05, 8'h10, 8'h00,
                                     8'h6F, 8'h00, 8'h00, 8'h00};
    int         gaps [12]        = '{0, 3, 1, 5, 0, 2, 0, 0, 0, 1, 4, 2};

    instruction_loader dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .byte_in           (byte_in),
        .byte_valid        (byte_valid),
        .byte_ready        (byte_ready),
        .mem_write_enable  (mem_write_enable),
        .mem_write_address (mem_write_address),
        .mem_write_data    (mem_write_data),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    instruction_loader #(.MEMORY_SIZE(1024), .BASE_ADDRESS(32'h0000_0100)) dut_b (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .byte_in           (byte_in),
        .byte_valid        (byte_valid),
        .byte_ready        (b_byte_ready),
        .mem_write_enable  (b_mem_write_enable),
        .mem_write_address (b_mem_write_address),
        .mem_write_data    (b_mem_write_data),
        .busy              (b_busy),
        .done              (b_done),
        .error             (b_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor: every cycle with the strobe high is logged once.
    always @(negedge clk) begin
        if (mem_write_enable === 1'b1) begin
            q_addr.push_back(mem_write_address);
            q_data.push_back(mem_write_data);
            if (byte_ready !== 1'b0) ready_during_write++;
        end
        if (b_mem_write_enable === 1'b1) qb_addr.push_back(b_mem_write_address);
    end

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        qb_addr.delete();
        ready_during_write = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called and returns at a negedge; leaves byte_valid high after the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_byte_timeout: byte %02h not accepted within 50 cycles", b);
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", name, done, limit);
        end
    endtask

    task automatic test_reset();
        tests_run += 7;
        if (byte_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_byte_ready: got %b want 0", byte_ready); end
        if (mem_write_enable !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b want 0", mem_write_enable); end
        if (mem_write_address !== 32'd0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", mem_write_address); end
        if (mem_write_data !== 32'd0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", mem_write_data); end
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        if (error !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b want 0", error); end
    endtask

    task automatic check_basic_result(input string name);
        tests_run += 4;
        if (q_addr.size() != 2) begin
            tests_failed++;
            $display("FAIL %s_strobe_count: got %0d want 2", name, q_addr.size());
        end else begin
            if (q_addr[0] !== 32'h0 || q_data[0] !== 32'h0010_0513) begin
                tests_failed++;
                $display("FAIL %s_word0: got addr %h data %h want 00000000 00100513", name, q_addr[0], q_data[0]);
            end
            if (q_addr[1] !== 32'h4 || q_data[1] !== 32'h0000_006F) begin
                tests_failed++;
                $display("FAIL %s_word1: got addr %h data %h want 00000004 0000006f", name, q_addr[1], q_data[1]);
            end
        end
        if (ready_during_write != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_flags: ready_in_write=%0d busy=%b want 0 0", name, ready_during_write, busy);
        end
    endtask

    task automatic test_basic_load();
        clear_log();
        pulse_start();
        tests_run++;
        if (busy !== 1'b1 || byte_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_header_entry: busy=%b ready=%b want 1 1", busy, byte_ready);
        end
        for (int i = 0; i < 12; i++) send_byte(basic_bytes[i], 0);
        byte_valid = 1'b0;
        wait_done("basic", 50);
        repeat (2) @(negedge clk);
        check_basic_result("basic");
    endtask

    task automatic test_empty_load();
        clear_log();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        byte_valid = 1'b0;
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_done_latency: done=%b busy=%b want 1 0", done, busy);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (q_addr.size() != 0) begin
            tests_failed++;
            $display("FAIL empty_no_strobe: got %0d strobes want 0", q_addr.size());
        end
    endtask

    task automatic test_oversize();
        logic [7:0]  k8;
        logic [31:0] exp_data;
        int          bad;
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        tests_run += 2;
        if (error !== 1'b1 || byte_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL oversize_flags: error=%b ready=%b busy=%b done=%b want 1 0 0 0", error, byte_ready, busy, done);
        end
        if (q_addr.size() != 0) begin
            tests_failed++;
            $display("FAIL oversize_no_strobe: got %0d strobes want 0", q_addr.size());
        end

        pulse_start();
        tests_run++;
        if (error !== 1'b0) begin
            tests_failed++;
            $display("FAIL oversize_error_clear: error=%b want 0", error);
        end
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 256; k++) begin
            k8 = 8'(k);
            send_byte(k8, 0);
            send_byte(8'h5A, 0);
            send_byte(~k8, 0);
            send_byte(8'hC3, 0);
        end
        byte_valid = 1'b0;
        wait_done("full", 50);
        repeat (2) @(negedge clk);
        tests_run += 2;
        if (q_addr.size() != 256) begin
            tests_failed++;
            $display("FAIL full_strobe_count: got %0d want 256", q_addr.size());
        end else begin
            bad = 0;
            for (int k = 0; k < 256; k++) begin
                k8 = 8'(k);
                exp_data = {8'hC3, ~k8, 8'h5A, k8};
                if (q_addr[k] !== 32'(k * 4) || q_data[k] !== exp_data) bad++;
            end
            if (bad != 0 || q_addr[255] !== 32'h3FC) begin
                tests_failed++;
                $display("FAIL full_contents: %0d bad words, last addr %h want 0 bad and 000003fc", bad, q_addr[255]);
            end
        end
        if (error !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_error: got %b want 0", error);
        end
    endtask

    task automatic test_throttled();
        clear_log();
        pulse_start();
        for (int i = 0; i < 12; i++) send_byte(basic_bytes[i], gaps[i]);
        byte_in = 8'hEE;
        wait_done("throttled", 50);
        repeat (5) @(negedge clk);
        tests_run++;
        if (byte_ready !== 1'b0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL throttled_hold: ready=%b done=%b want 0 1", byte_ready, done);
        end
        byte_valid = 1'b0;
        check_basic_result("throttled");
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(basic_bytes[i], 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        byte_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        tests_run += 2;
        if (busy !== 1'b0 || byte_ready !== 1'b0 || mem_write_enable !== 1'b0 ||
            mem_write_address !== 32'd0 || mem_write_data !== 32'd0 || done !== 1'b0 || error !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: busy=%b ready=%b we=%b addr=%h data=%h done=%b err=%b want all 0",
                     busy, byte_ready, mem_write_enable, mem_write_address, mem_write_data, done, error);
        end
        if (q_addr.size() != 1) begin
            tests_failed++;
            $display("FAIL midreset_strobes_before: got %0d want 1", q_addr.size());
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_log();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        byte_valid = 1'b0;
        wait_done("midreset", 50);
        repeat (2) @(negedge clk);
        tests_run++;
        if (q_addr.size() != 1 || q_addr[0] !== 32'h0 || q_data[0] !== 32'hEFBE_ADDE) begin
            tests_failed++;
            $display("FAIL midreset_reload: count %0d addr %h data %h want 1 00000000 efbeadde",
                     q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 32'hX, (q_data.size() > 0) ? q_data[0] : 32'hX);
        end
    endtask

    task automatic test_start_while_busy();
        clear_log();
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        byte_valid = 1'b0;
        pulse_start();
        send_byte(8'h77, 1);
        send_byte(8'h88, 0);
        byte_valid = 1'b0;
        wait_done("busy_start", 50);
        repeat (2) @(negedge clk);
        tests_run += 2;
        if (q_addr.size() != 2 || q_addr[0] !== 32'h0 || q_data[0] !== 32'h4433_2211 ||
            q_addr[1] !== 32'h4 || q_data[1] !== 32'h8877_6655) begin
            tests_failed++;
            $display("FAIL busy_start_words: count %0d want 2 words 0:44332211 4:88776655", q_addr.size());
        end
        if (qb_addr.size() != 2 || qb_addr[0] !== 32'h100 || qb_addr[1] !== 32'h104) begin
            tests_failed++;
            $display("FAIL base_address: count %0d first %h want 2 with 00000100 00000104",
                     qb_addr.size(), (qb_addr.size() > 0) ? qb_addr[0] : 32'hX);
        end
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        #3;
        test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        test_basic_load();
        test_empty_load();
        test_oversize();
        test_throttled();
        test_reset_mid_load();
        test_start_while_busy();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
